// File: rtl/io_bridge_pkg.sv
// Shared definitions for the FPGA board-side I/O bridge.
// Holds the control FSM state encoding and the default port channel width.
package io_bridge_pkg;

  // Default width of one CPU port channel.
  localparam int unsigned DefaultDataW = 16;

  // Control FSM encoding. 2'd3 is never entered; the FSM recovers to StRun from it.
  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStep   = 2'd1,
    StHalted = 2'd2
  } io_state_e;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a stability-count debouncer.
// The synchronised word is compared with its previous sample; after DB_CYC consecutive
// matching samples the word is loaded into the debounced output.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   d_raw - raw asynchronous input word
//   d_db  - registered debounced word
module io_debounce #(
  parameter int unsigned W      = 1,
  parameter int unsigned DB_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_raw,
  output logic [W-1:0] d_db
);

  localparam int unsigned CntW = $clog2(DB_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYC);

  logic [W-1:0]    sync1_q, sync1_d;
  logic [W-1:0]    sync2_q, sync2_d;
  logic [W-1:0]    prev_q, prev_d;
  logic [W-1:0]    db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = d_raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else begin
      // Saturate at DB_CYC so a long stable run keeps reloading the same word.
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_d == CntMax) begin
        db_d = prev_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_db = db_q;

endmodule

// File: rtl/fpga_io_bridge.sv
// Board-side I/O bridge between the CPU port bus and FPGA pins.
// Generates the CPU clock enable (programmable divider in RUN, debounced button in STEP,
// none in HALTED), debounces switch channels onto port_in and latches LED words written
// by the CPU on enabled cycles.
// Ports:
//   clk, rst_n          - system clock, synchronous active-low reset
//   div_ratio           - cpu_ce period in RUN is div_ratio+1 cycles
//   step_mode, step_btn - single-step select and raw step button
//   sw / port_in        - raw switch channels / debounced values to the CPU
//   port_out / port_we  - CPU output data and per-channel write strobes
//   cpu_halt            - CPU halt flag, honoured on a cpu_ce cycle
//   cpu_ce              - one-cycle CPU clock enable
//   led                 - latched LED drive
//   state_o             - current FSM state
module fpga_io_bridge
  import io_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned N_IN   = 1,
  parameter int unsigned N_OUT  = 1,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned DB_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DIV_W-1:0]        div_ratio,
  input  logic                    step_mode,
  input  logic                    step_btn,
  input  logic [N_IN*DATA_W-1:0]  sw,
  output logic [N_IN*DATA_W-1:0]  port_in,
  input  logic [N_OUT*DATA_W-1:0] port_out,
  input  logic [N_OUT-1:0]        port_we,
  input  logic                    cpu_halt,
  output logic                    cpu_ce,
  output logic [N_OUT*DATA_W-1:0] led,
  output logic [1:0]              state_o
);

  logic [1:0]              state_q, state_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic                    ce_q, ce_d;
  logic                    step_prev_q, step_prev_d;
  logic [N_OUT*DATA_W-1:0] led_q, led_d;
  logic                    step_db;
  logic                    step_rise;

  for (genvar i = 0; i < N_IN; i++) begin : g_sw
    io_debounce #(
      .W     (DATA_W),
      .DB_CYC(DB_CYC)
    ) u_sw_db (
      .clk  (clk),
      .rst_n(rst_n),
      .d_raw(sw[i*DATA_W +: DATA_W]),
      .d_db (port_in[i*DATA_W +: DATA_W])
    );
  end

  io_debounce #(
    .W     (1),
    .DB_CYC(DB_CYC)
  ) u_step_db (
    .clk  (clk),
    .rst_n(rst_n),
    .d_raw(step_btn),
    .d_db (step_db)
  );

  assign step_rise = step_db & ~step_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ce_d        = 1'b0;
    step_prev_d = step_db;
    case (state_q)
      StRun: begin
        if (cpu_halt && ce_q) begin
          state_d = StHalted;
          cnt_d   = '0;
        end else if (step_mode) begin
          state_d = StStep;
          cnt_d   = '0;
        end else if (cnt_q >= div_ratio) begin
          // '>=' lets a lowered div_ratio wrap immediately instead of overrunning.
          cnt_d = '0;
          ce_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      StStep: begin
        if (cpu_halt && ce_q) begin
          state_d = StHalted;
        end else if (!step_mode) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          ce_d = step_rise;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    led_d = led_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (port_we[i] && ce_q) begin
        led_d[i*DATA_W +: DATA_W] = port_out[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      step_prev_q <= 1'b0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_q        <= ce_d;
      step_prev_q <= step_prev_d;
      led_q       <= led_d;
    end
  end

  assign cpu_ce  = ce_q;
  assign led     = led_q;
  assign state_o = state_q;

endmodule

// File: doc/fpga_io_bridge.md
Name: fpga_io_bridge

Overview:
- Parametrised board-side I/O bridge between the CPU port bus and FPGA pins.
- Replaces the fixed toggle-divided CPU clock and hard-wired single switch/LED port.
- Provides a programmable clock-enable divider, run/single-step/halt control, synchronised and debounced switch channels, and write-strobed LED latches for N channels.
- Instanced inside the board top; the CPU runs on `clk`, gated by `cpu_ce`.

Parameters:
- DATA_W, 16, width of one port channel.
- N_IN, 1, number of switch input channels (port_in[i] feeds CPU input port i+1).
- N_OUT, 1, number of LED output channels (led[i] is taken from CPU output port i+1).
- DIV_W, 8, width of the divide-ratio input and the divide counter.
- DB_CYC, 4, number of consecutive stable synchronised samples required before a debounced input updates (≥1).

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- div_ratio, in, DIV_W, `cpu_ce` asserts once every div_ratio+1 clk cycles in RUN.
- step_mode, in, 1, 1 = single-step mode, 0 = free run.
- step_btn, in, 1, raw step button (asynchronous to clk).
- sw, in, N_IN*DATA_W, raw switches (asynchronous); channel i occupies bits [i*DATA_W +: DATA_W].
- port_in, out, N_IN*DATA_W, debounced switch values presented to the CPU.
- port_out, in, N_OUT*DATA_W, CPU output port data.
- port_we, in, N_OUT, per-channel CPU write strobe.
- cpu_halt, in, 1, CPU halt flag.
- cpu_ce, out, 1, one-clk-wide CPU clock enable.
- led, out, N_OUT*DATA_W, latched LED drive.
- state_o, out, 2, current FSM state encoding.

Behaviour:
- Reset (`rst_n` low at a clk edge): `led`=0, `port_in`=0, `cpu_ce`=0, divide counter=0, debounce counters=0, synchronisers=0, state=RUN.
  - A reset asserted mid-operation takes effect at the next edge and overrides every other event.
- FSM states: RUN=0, STEP=1, HALTED=2. The encoding is 3 and never reached; if it occurs, the next state is RUN.
  - RUN→STEP when `step_mode`=1; the divide counter clears to 0 on entry.
  - STEP→RUN when `step_mode`=0; the counter starts from 0.
  - RUN/STEP→HALTED when `cpu_halt`=1 in a cycle with `cpu_ce`=1.
  - HALTED is left only by reset. In HALTED, `cpu_ce`=0 and `step_btn` is ignored.
  - Halt takes priority over a simultaneous mode change.
- Divider (RUN only):
  - `cpu_ce` is registered and is 1 in the cycle after the counter equals `div_ratio`; the counter then wraps to 0.
  - `div_ratio`=0 gives `cpu_ce`=1 every cycle.
  - If `div_ratio` is lowered below the current count, the counter wraps to 0 and issues `cpu_ce`; no overrun to 2^DIV_W.
- Step (STEP only):
  - `step_btn` passes through a 2-FF synchroniser, then the DB_CYC debouncer, then rising-edge detection.
  - Each debounced rising edge produces exactly one `cpu_ce` pulse, on the cycle after the edge.
  - Holding the button produces no further pulses.
- Switch inputs:
  - Each `sw` bit passes through a 2-FF synchroniser.
  - Per channel, a counter (width $clog2(DB_CYC+1)) counts consecutive cycles in which the synchronised word equals its previous sample; any change clears it.
  - When the count reaches DB_CYC, `port_in[i]` is loaded with the word.
  - Latency from a clean step to `port_in` is 2+DB_CYC+1 cycles.
- LED latches:
  - `led[i]` loads `port_out[i]` when `port_we[i]`=1 and `cpu_ce`=1 in the same cycle. Strobes without `cpu_ce` are ignored.
  - LEDs hold their value in HALTED and across mode changes.
  - Simultaneous writes to different channels all take effect.
- No combinational paths from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package `io_bridge_pkg`: state enum (RUN, STEP, HALTED) and the default DATA_W.
- Sub-module `io_debounce` (params W, DB_CYC; ports clk, rst_n, d_raw, d_db):
  - contains the synchroniser and the stability counter;
  - instanced once per switch channel and once (W=1) for `step_btn`.

Test Plan:
- Reset, then `div_ratio`=3, `step_mode`=0 → `cpu_ce` pulses on every 4th cycle, first at cycle 4 after reset release; `led`=0 and `port_in`=0 until written.
- `sw[15:0]`=16'hA5A5 with 2-cycle glitches to 16'h0000 at DB_CYC=4 → `port_in` stays 0 during glitches. After a clean hold, `port_in`=16'hA5A5 exactly 7 cycles after the last change.
- `step_mode`=1 with three debounced `step_btn` presses, one held 50 cycles → exactly 3 `cpu_ce` pulses; `port_we`=1 with `port_out`=16'h1234 outside a CE cycle → `led` unchanged.
- RUN, `div_ratio`=0, `port_we`=1, `port_out`=16'hBEEF, `cpu_halt`=1 on the same CE → `led`=16'hBEEF, state=HALTED, `cpu_ce`=0 thereafter, step presses ignored; `rst_n`=0 → state RUN, `led`=0.
- `div_ratio` changed from 200 to 5 while the counter is at 100 → `cpu_ce` is issued on the next cycle, then every 6 cycles.
- N_OUT=2, N_IN=2: simultaneous `port_we`=2'b11 on a CE with 16'h0001 / 16'h0002 → both `led` channels update together; `sw` channels debounce independently.
